// File: rtl/logic_unit_pipe_if.sv
// Handshake bus for logic_unit_pipe: operation input side, result output side
// and the architectural condition-code register.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             out_zf;
    logic             out_sf;
    logic             out_of;
    logic [2:0]       cc;

    modport slave (
        input  in_valid, op, a, b, set_cc, out_ready,
        output in_ready, out_valid, result, out_zf, out_sf, out_of, cc
    );

    modport master (
        output in_valid, op, a, b, set_cc, out_ready,
        input  in_ready, out_valid, result, out_zf, out_sf, out_of, cc
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (AND/OR/XOR/XNOR) with Y86-style flags,
// valid/ready backpressure and an architectural {ZF,SF,OF} register.
module logic_unit_pipe #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave io_bus
);
    localparam int unsigned Last = STAGES - 1;

    logic [WIDTH-1:0]  w_res;
    logic              w_zf;
    logic              w_sf;
    logic              w_chain;
    logic              w_in_ready;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_res [STAGES];
    logic [STAGES-1:0] r_zf;
    logic [STAGES-1:0] r_sf;
    logic [STAGES-1:0] r_scc;
    logic [2:0]        r_cc;

    always_comb begin
        unique case (io_bus.op)
            2'b00:   w_res = io_bus.a & io_bus.b;
            2'b01:   w_res = io_bus.a | io_bus.b;
            2'b10:   w_res = io_bus.a ^ io_bus.b;
            default: w_res = ~(io_bus.a ^ io_bus.b);
        endcase
        w_zf = (w_res == '0);
        w_sf = w_res[WIDTH-1];
    end

    // Walk back from the output: a stage may advance if out_ready or any later stage is empty.
    always_comb begin
        w_chain = io_bus.out_ready;
        w_adv   = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            w_adv[k] = w_chain;
            w_chain  = w_chain | ~r_valid[k];
        end
        w_in_ready = w_chain;
    end

    assign w_load = w_adv | ~r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_zf    <= '0;
            r_sf    <= '0;
            r_scc   <= '0;
            r_cc    <= 3'b100;
            for (int k = 0; k < int'(STAGES); k++) begin
                r_res[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= io_bus.in_valid;
                // Payload only moves with a valid op so idle outputs keep their last value.
                if (io_bus.in_valid) begin
                    r_res[0] <= w_res;
                    r_zf[0]  <= w_zf;
                    r_sf[0]  <= w_sf;
                    r_scc[0] <= io_bus.set_cc;
                end
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_res[k] <= r_res[k-1];
                        r_zf[k]  <= r_zf[k-1];
                        r_sf[k]  <= r_sf[k-1];
                        r_scc[k] <= r_scc[k-1];
                    end
                end
            end
            if (r_valid[Last] && io_bus.out_ready && r_scc[Last]) begin
                r_cc <= {r_zf[Last], r_sf[Last], 1'b0};
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_valid[Last];
    assign io_bus.result    = r_res[Last];
    assign io_bus.out_zf    = r_zf[Last];
    assign io_bus.out_sf    = r_sf[Last];
    assign io_bus.out_of    = 1'b0;
    assign io_bus.cc        = r_cc;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: vector table through the default 64/2 unit,
// then backpressure, CC gating, mid-flight reset and 8-bit latency sweeps.
module tb_logic_unit_pipe;
    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        scc;
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic [2:0]  cc;
    } vec_t;

    localparam int NumVec = 9;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    vec_t vecs [NumVec];

    logic_unit_pipe_if #(.WIDTH(64)) bus64 ();
    logic_unit_pipe_if #(.WIDTH(8))  bus_s1 ();
    logic_unit_pipe_if #(.WIDTH(8))  bus_s4 ();

    logic_unit_pipe #(.WIDTH(64), .STAGES(2)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus64.slave)
    );
    logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_s1.slave)
    );
    logic_unit_pipe #(.WIDTH(8), .STAGES(4)) u_dut_s4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_s4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic scc);
        bus64.in_valid = 1'b1;
        bus64.op       = op;
        bus64.a        = a;
        bus64.b        = b;
        bus64.set_cc   = scc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat1;
        int lat4;
        int lat;
        logic [7:0]  res1;
        logic [7:0]  res4;
        logic        sf1;
        logic        sf4;
        logic [63:0] res;

        tests = 0;
        fails = 0;
        vecs[0] = '{2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 3'b000};
        vecs[1] = '{2'b10, 64'h1, 64'h2, 1'b1, 64'h3, 1'b0, 1'b0, 3'b000};
        vecs[2] = '{2'b10, 64'h3, 64'h7, 1'b1, 64'h4, 1'b0, 1'b0, 3'b000};
        vecs[3] = '{2'b11, 64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 3'b010};
        vecs[4] = '{2'b00, 64'hF0, 64'h0F, 1'b1, 64'h0, 1'b1, 1'b0, 3'b100};
        vecs[5] = '{2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 3'b010};
        vecs[6] = '{2'b01, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 3'b010};
        vecs[7] = '{2'b00, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0,
                    64'h0F00_0F00_0F00_0F00, 1'b0, 1'b0, 3'b010};
        vecs[8] = '{2'b11, 64'h8000_0000_0000_0000, 64'h0, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 3'b000};

        rst_n = 1'b0;
        bus64.in_valid  = 1'b0; bus64.op  = 2'b00; bus64.a  = '0; bus64.b  = '0;
        bus64.set_cc    = 1'b0; bus64.out_ready  = 1'b1;
        bus_s1.in_valid = 1'b0; bus_s1.op = 2'b00; bus_s1.a = '0; bus_s1.b = '0;
        bus_s1.set_cc   = 1'b0; bus_s1.out_ready = 1'b1;
        bus_s4.in_valid = 1'b0; bus_s4.op = 2'b00; bus_s4.a = '0; bus_s4.b = '0;
        bus_s4.set_cc   = 1'b0; bus_s4.out_ready = 1'b1;

        // Reset state
        #7;
        check("rst_out_valid", 64'(bus64.out_valid), 64'h0);
        check("rst_result", bus64.result, 64'h0);
        check("rst_flags", {61'h0, bus64.out_zf, bus64.out_sf, bus64.out_of}, 64'h0);
        check("rst_cc", 64'(bus64.cc), 64'h4);
        #5 rst_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(bus64.in_ready), 64'h1);

        // Table: back-to-back ops, output of vec t-1 after edge t, cc of vec t-2 after edge t
        for (int t = 0; t <= NumVec + 1; t++) begin
            if (t < NumVec) begin
                drive64(vecs[t].op, vecs[t].a, vecs[t].b, vecs[t].scc);
                #1;
                check($sformatf("v%0d_in_ready", t), 64'(bus64.in_ready), 64'h1);
            end else begin
                bus64.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (t >= 1 && t - 1 < NumVec) begin
                check($sformatf("v%0d_out_valid", t - 1), 64'(bus64.out_valid), 64'h1);
                check($sformatf("v%0d_result", t - 1), bus64.result, vecs[t-1].res);
                check($sformatf("v%0d_zf", t - 1), 64'(bus64.out_zf), 64'(vecs[t-1].zf));
                check($sformatf("v%0d_sf", t - 1), 64'(bus64.out_sf), 64'(vecs[t-1].sf));
                check($sformatf("v%0d_of", t - 1), 64'(bus64.out_of), 64'h0);
            end
            if (t >= 2) begin
                check($sformatf("v%0d_cc", t - 2), 64'(bus64.cc), 64'(vecs[t-2].cc));
            end
        end
        check("tbl_drain_valid", 64'(bus64.out_valid), 64'h0);

        // Backpressure: two ops fill the pipe, third is held off
        bus64.out_ready = 1'b0;
        drive64(2'b10, 64'h11, 64'h0, 1'b0);
        tick();
        drive64(2'b10, 64'h22, 64'h0, 1'b0);
        tick();
        drive64(2'b10, 64'h33, 64'h0, 1'b0);
        #1;
        check("bp_full_in_ready", 64'(bus64.in_ready), 64'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", i), 64'(bus64.out_valid), 64'h1);
            check($sformatf("bp_hold%0d_result", i), bus64.result, 64'h11);
            check($sformatf("bp_hold%0d_in_ready", i), 64'(bus64.in_ready), 64'h0);
        end
        bus64.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(bus64.in_ready), 64'h1);
        tick();
        bus64.in_valid = 1'b0;
        check("bp_second", bus64.result, 64'h22);
        check("bp_second_valid", 64'(bus64.out_valid), 64'h1);
        tick();
        check("bp_third", bus64.result, 64'h33);
        check("bp_third_valid", 64'(bus64.out_valid), 64'h1);
        tick();
        check("bp_empty_valid", 64'(bus64.out_valid), 64'h0);
        check("bp_idle_result_held", bus64.result, 64'h33);
        check("bp_cc_unchanged", 64'(bus64.cc), 64'h0);

        // Reset with two ops in flight
        drive64(2'b10, 64'h1, 64'h0, 1'b1);
        tick();
        drive64(2'b10, 64'h2, 64'h0, 1'b1);
        tick();
        bus64.in_valid = 1'b0;
        check("mr_pre_valid", 64'(bus64.out_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mr_async_valid", 64'(bus64.out_valid), 64'h0);
        check("mr_async_result", bus64.result, 64'h0);
        check("mr_async_cc", 64'(bus64.cc), 64'h4);
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr_nostale%0d", i), 64'(bus64.out_valid), 64'h0);
            check($sformatf("mr_cc%0d", i), 64'(bus64.cc), 64'h4);
        end
        check("mr_in_ready", 64'(bus64.in_ready), 64'h1);
        drive64(2'b00, 64'hFF, 64'h0F, 1'b1);
        lat = 0;
        res = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus64.in_valid = 1'b0;
            if (bus64.out_valid && lat == 0) begin
                lat = c;
                res = bus64.result;
            end
        end
        check("mr_new_latency", 64'(lat), 64'h2);
        check("mr_new_result", res, 64'h0F);

        // Width 8, STAGES 1 and 4 latency sweep
        bus_s1.in_valid = 1'b1; bus_s1.op = 2'b10; bus_s1.a = 8'h80; bus_s1.b = 8'h00;
        bus_s4.in_valid = 1'b1; bus_s4.op = 2'b10; bus_s4.a = 8'h80; bus_s4.b = 8'h00;
        lat1 = 0; lat4 = 0; res1 = '0; res4 = '0; sf1 = 1'b0; sf4 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus_s1.in_valid = 1'b0;
            bus_s4.in_valid = 1'b0;
            if (bus_s1.out_valid && lat1 == 0) begin
                lat1 = c; res1 = bus_s1.result; sf1 = bus_s1.out_sf;
            end
            if (bus_s4.out_valid && lat4 == 0) begin
                lat4 = c; res4 = bus_s4.result; sf4 = bus_s4.out_sf;
            end
        end
        check("s1_latency", 64'(lat1), 64'h1);
        check("s1_result", 64'(res1), 64'h80);
        check("s1_sf", 64'(sf1), 64'h1);
        check("s4_latency", 64'(lat4), 64'h4);
        check("s4_result", 64'(res4), 64'h80);
        check("s4_sf", 64'(sf4), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
